eth_tx_frame_arb: RTL

Frame-granular round-robin arbiter that shares one Ethernet MAC AXI-stream transmit input between NUM_SRC requesters. A grant holds for one complete frame (through the beat with tlast), so frames from different sources are never interleaved. It sits between the packet sources (UDP/IP layers, test injectors) and the MAC transmit path. An optional watchdog terminates frames whose source stalls mid-frame.

---
 rtl/eth_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/eth_tx_frame_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
// The watchdog states are used only when FRAME_ARB_WATCHDOG_EN is defined.
package eth_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPass  = 2'd1,
      StAbort = 2'd2,
      StDrain = 2'd3
   } arb_state_e;

   localparam int unsigned DefaultTimeout = 1024;

   // A limit of 1 still needs one counter bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NumSrc = 2
) (
   input  logic [NumSrc-1:0]         req_i,
   input  logic [$clog2(NumSrc)-1:0] ptr_i,
   output logic [NumSrc-1:0]         pick_o,
   output logic                      valid_o
);

   localparam int unsigned PtrW = $clog2(NumSrc);

   always_comb begin
      logic [PtrW-1:0] idx;
      pick_o  = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = 0; k < NumSrc; k++) begin
         idx = PtrW'((int'(ptr_i) + k) % NumSrc);
         if (!valid_o && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter in front of the MAC transmit stream.
// Define FRAME_ARB_WATCHDOG_EN to terminate frames whose source stalls mid-frame.
module eth_tx_frame_arb
   import eth_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned TIMEOUT    = DefaultTimeout
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tx_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_tx_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_tx_axis_tlast,
   input  logic [NUM_SRC-1:0]            s_tx_axis_tuser,
   output logic [NUM_SRC-1:0]            s_tx_axis_trdy,
   output logic [DATA_WIDTH-1:0]         m_tx_axis_tdata,
   output logic                          m_tx_axis_tvalid,
   output logic                          m_tx_axis_tlast,
   output logic                          m_tx_axis_tuser,
   input  logic                          m_tx_axis_trdy,
   output logic [NUM_SRC-1:0]            grant
);

   localparam int unsigned PtrW = $clog2(NUM_SRC);

   arb_state_e          state_q, state_d;
   logic [PtrW-1:0]     ptr_q, ptr_d;
   logic [PtrW-1:0]     gidx_q, gidx_d;
   logic [NUM_SRC-1:0]  grant_q, grant_d;
   logic [NUM_SRC-1:0]  pick;
   logic                pick_valid;
   logic [PtrW-1:0]     pick_idx;
   logic [PtrW-1:0]     next_ptr;
   logic [DATA_WIDTH-1:0] src_data;
   logic                src_valid, src_last, src_user;

`ifdef FRAME_ARB_WATCHDOG_EN
   localparam int unsigned CntW = cnt_width(TIMEOUT);
   logic [CntW-1:0] wd_q, wd_d;
   logic            wd_expired;
   assign wd_expired = (wd_q == CntW'(TIMEOUT - 1));
`endif

   rr_arbiter #(
      .NumSrc (NUM_SRC)
   ) u_rr_arbiter (
      .req_i   (s_tx_axis_tvalid),
      .ptr_i   (ptr_q),
      .pick_o  (pick),
      .valid_o (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pick[i]) pick_idx = PtrW'(i);
      end
   end

   // Index register mirrors grant so the data mux needs no one-hot decode.
   assign src_data  = s_tx_axis_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
   assign src_valid = s_tx_axis_tvalid[gidx_q];
   assign src_last  = s_tx_axis_tlast[gidx_q];
   assign src_user  = s_tx_axis_tuser[gidx_q];
   assign next_ptr  = (gidx_q == PtrW'(NUM_SRC - 1)) ? '0 : gidx_q + 1'b1;
   assign grant     = grant_q;

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      gidx_d           = gidx_q;
      grant_d          = grant_q;
      m_tx_axis_tdata  = '0;
      m_tx_axis_tvalid = 1'b0;
      m_tx_axis_tlast  = 1'b0;
      m_tx_axis_tuser  = 1'b0;
      s_tx_axis_trdy   = '0;
`ifdef FRAME_ARB_WATCHDOG_EN
      wd_d             = '0;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick;
               gidx_d  = pick_idx;
               state_d = StPass;
            end
         end
         StPass: begin
            m_tx_axis_tdata  = src_data;
            m_tx_axis_tvalid = src_valid;
            m_tx_axis_tlast  = src_last;
            m_tx_axis_tuser  = src_user;
            s_tx_axis_trdy   = grant_q & {NUM_SRC{m_tx_axis_trdy}};
`ifdef FRAME_ARB_WATCHDOG_EN
            wd_d = src_valid ? '0 : wd_q + 1'b1;
`endif
            if (src_valid && m_tx_axis_trdy && src_last) begin
               state_d = StIdle;
               grant_d = '0;
               ptr_d   = next_ptr;
            end
`ifdef FRAME_ARB_WATCHDOG_EN
            else if (wd_expired) begin
               state_d = StAbort;
            end
`endif
         end
`ifdef FRAME_ARB_WATCHDOG_EN
         // Close the frame on the MAC side as a bad frame.
         StAbort: begin
            m_tx_axis_tvalid = 1'b1;
            m_tx_axis_tlast  = 1'b1;
            m_tx_axis_tuser  = 1'b1;
            if (m_tx_axis_trdy) state_d = StDrain;
         end
         StDrain: begin
            s_tx_axis_trdy = grant_q;
            if (src_valid && src_last) begin
               state_d = StIdle;
               grant_d = '0;
               ptr_d   = next_ptr;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
`ifdef FRAME_ARB_WATCHDOG_EN
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
`ifdef FRAME_ARB_WATCHDOG_EN
         wd_q    <= wd_d;
`endif
      end
   end

endmodule
